// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Five-stage pipeline hazard controller: post-reset flush, memory
//            wait stalls with timeout, branch redirects, load-use stalls and
//            saturating stall/redirect statistics.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int INIT_CYCLES = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic        rs1_usedD,
    input  logic        rs2_usedD,
    input  logic [4:0]  rdE,
    input  logic        mem_readE,
    input  logic        br_takenE,
    input  logic        mem_busyM,
    input  logic        cnt_clr,
    output logic        bubbleF,
    output logic        bubbleD,
    output logic        bubbleE,
    output logic        bubbleM,
    output logic        bubbleW,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [2:0]  c_init_last = (INIT_CYCLES > 1) ? 3'(INIT_CYCLES - 1) : 3'd0;
    localparam logic [7:0]  c_wait_max  = 8'(MEM_TIMEOUT);
    localparam logic [15:0] c_cnt_max   = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_init_cnt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_redir_cnt;
    logic        r_timeout;
    logic        w_load_use;
    logic        w_redirect;
    logic        w_stall_inc;
    logic        w_timeout_set;

    assign w_load_use = mem_readE & (rdE != 5'd0) &
                        ((rs1_usedD & (rs1D == rdE)) | (rs2_usedD & (rs2D == rdE)));

    // Next state and stage controls; reset holds r_state at INIT so the
    // INIT decode is also what the pipeline sees while rst_n is low.
    always_comb begin
        w_state_nxt = r_state;
        w_redirect  = 1'b0;
        bubbleF     = 1'b0;
        bubbleD     = 1'b0;
        bubbleE     = 1'b0;
        bubbleM     = 1'b0;
        bubbleW     = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushM      = 1'b0;
        flushW      = 1'b0;
        case (r_state)
            ST_INIT: begin
                bubbleF = 1'b1;
                flushD  = 1'b1;
                flushE  = 1'b1;
                flushM  = 1'b1;
                flushW  = 1'b1;
                if (r_init_cnt >= c_init_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                if (mem_busyM) begin
                    // EX is frozen, so a taken branch there is replayed once memory frees up
                    bubbleF     = 1'b1;
                    bubbleD     = 1'b1;
                    bubbleE     = 1'b1;
                    bubbleM     = 1'b1;
                    flushW      = 1'b1;
                    w_state_nxt = ST_MEMWAIT;
                end else if (br_takenE) begin
                    flushD      = 1'b1;
                    flushE      = 1'b1;
                    w_redirect  = 1'b1;
                    w_state_nxt = ST_RUN;
                end else if (w_load_use) begin
                    bubbleF     = 1'b1;
                    bubbleD     = 1'b1;
                    flushE      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    assign w_stall_inc = (r_state != ST_INIT) & bubbleF;

    // Wait counter restarts on the RUN->MEMWAIT edge and counts MEMWAIT busy cycles
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if ((r_state == ST_RUN) && mem_busyM) begin
            w_wait_nxt = 8'd0;
        end else if ((r_state == ST_MEMWAIT) && mem_busyM && (r_wait_cnt != c_wait_max)) begin
            w_wait_nxt = r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout_set = (r_state == ST_MEMWAIT) & mem_busyM & (w_wait_nxt == c_wait_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt <= 3'd0;
        end else if ((r_state == ST_INIT) && (r_init_cnt < c_init_last)) begin
            r_init_cnt <= r_init_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
            r_redir_cnt <= 16'd0;
        end else if (cnt_clr) begin
            r_stall_cnt <= 16'd0;
            r_redir_cnt <= 16'd0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect && (r_redir_cnt != c_cnt_max)) begin
                r_redir_cnt <= r_redir_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign redirect_cnt = r_redir_cnt;
    assign mem_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Scoreboard bench for pipe_hazard_ctrl; directed vectors push
//            expected outputs, a negedge monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    // {bubbleF,bubbleD,bubbleE,bubbleM,bubbleW,flushD,flushE,flushM,flushW}
    localparam logic [8:0] c_INIT = 9'b10000_1111;
    localparam logic [8:0] c_IDLE = 9'b00000_0000;
    localparam logic [8:0] c_LU   = 9'b11000_0100;
    localparam logic [8:0] c_BR   = 9'b00000_1100;
    localparam logic [8:0] c_MEM  = 9'b11110_0001;

    typedef struct {
        string       name;
        logic [41:0] exp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1D, rs2D, rdE;
    logic        rs1_usedD, rs2_usedD, mem_readE, br_takenE, mem_busyM, cnt_clr;
    logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic        flushD, flushE, flushM, flushW;
    logic [15:0] stall_cnt, redirect_cnt;
    logic        mem_timeout;

    exp_t        q[$];
    exp_t        m_e;
    logic [41:0] m_act;
    logic        chk;
    int          tests;
    int          fails;

    pipe_hazard_ctrl #(
        .INIT_CYCLES (3),
        .MEM_TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1D         (rs1D),
        .rs2D         (rs2D),
        .rs1_usedD    (rs1_usedD),
        .rs2_usedD    (rs2_usedD),
        .rdE          (rdE),
        .mem_readE    (mem_readE),
        .br_takenE    (br_takenE),
        .mem_busyM    (mem_busyM),
        .cnt_clr      (cnt_clr),
        .bubbleF      (bubbleF),
        .bubbleD      (bubbleD),
        .bubbleE      (bubbleE),
        .bubbleM      (bubbleM),
        .bubbleW      (bubbleW),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .flushW       (flushW),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt),
        .mem_timeout  (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are settled half a cycle after inputs change
    always @(negedge clk) begin
        if (chk) begin
            m_act = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                     flushD, flushE, flushM, flushW,
                     stall_cnt, redirect_cnt, mem_timeout};
            tests = tests + 1;
            if (q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL scoreboard_underflow: got %h, expected queue entry", m_act);
            end else begin
                m_e = q.pop_front();
                if (m_act !== m_e.exp) begin
                    fails = fails + 1;
                    $display("FAIL %s: got ctrl=%b stall=%h redir=%h to=%b, expected ctrl=%b stall=%h redir=%h to=%b",
                             m_e.name, m_act[41:33], m_act[32:17], m_act[16:1], m_act[0],
                             m_e.exp[41:33], m_e.exp[32:17], m_e.exp[16:1], m_e.exp[0]);
                end
            end
        end
    end

    task automatic step(input string nm, input logic rst,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic mr,
                        input logic br, input logic busy, input logic clr,
                        input logic do_chk, input logic [8:0] ec,
                        input logic [15:0] es, input logic [15:0] er, input logic et);
        exp_t e;
        rst_n     = rst;
        rs1D      = r1;
        rs1_usedD = u1;
        rs2D      = r2;
        rs2_usedD = u2;
        rdE       = rd;
        mem_readE = mr;
        br_takenE = br;
        mem_busyM = busy;
        cnt_clr   = clr;
        chk       = do_chk;
        if (do_chk) begin
            e.name = nm;
            e.exp  = {ec, es, er, et};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic [8:0] ec,
                        input logic [15:0] es, input logic [15:0] er, input logic et);
        step(nm, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ec, es, er, et);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        chk   = 1'b0;
        rst_n = 1'b0;
        rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0;
        rs1_usedD = 1'b0; rs2_usedD = 1'b0; mem_readE = 1'b0;
        br_takenE = 1'b0; mem_busyM = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;

        step("rst_held", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_INIT, 16'd0, 16'd0, 1'b0);
        // INIT ignores hazards, branches and memory busy
        for (int i = 0; i < 3; i++) begin
            step($sformatf("init_%0d", i), 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0,
                 1'b1, c_INIT, 16'd0, 16'd0, 1'b0);
        end
        idle("run_idle", c_IDLE, 16'd0, 16'd0, 1'b0);

        step("lu_rs1", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c_LU, 16'd0, 16'd0, 1'b0);
        idle("after_lu", c_IDLE, 16'd1, 16'd0, 1'b0);
        step("lu_rd0", 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c_IDLE, 16'd1, 16'd0, 1'b0);
        step("lu_rs2", 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c_LU, 16'd1, 16'd0, 1'b0);
        step("lu_unused", 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c_IDLE, 16'd2, 16'd0, 1'b0);
        step("no_load", 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_IDLE, 16'd2, 16'd0, 1'b0);

        step("br_and_lu", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, c_BR, 16'd2, 16'd0, 1'b0);
        idle("after_br", c_IDLE, 16'd2, 16'd1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            step($sformatf("busy_br_%0d", i), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0,
                 1'b1, c_MEM, 16'(2 + i), 16'd1, 1'b0);
        end
        step("br_after_busy", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, c_BR, 16'd6, 16'd1, 1'b0);
        idle("after_busy", c_IDLE, 16'd6, 16'd2, 1'b0);
        step("clr_idle", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c_IDLE, 16'd6, 16'd2, 1'b0);
        idle("clr_result", c_IDLE, 16'd0, 16'd0, 1'b0);

        // First busy cycle is the RUN->MEMWAIT entry; 255 MEMWAIT cycles follow before the flag
        for (int i = 0; i < 300; i++) begin
            step($sformatf("busy_to_%0d", i), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, c_MEM, 16'(i), 16'd0, (i >= 256));
        end
        idle("to_sticky", c_IDLE, 16'd300, 16'd0, 1'b1);
        step("clr2", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c_IDLE, 16'd300, 16'd0, 1'b1);

        for (int i = 0; i < 65535; i++) begin
            step("lu_fill", 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0,
                 (i == 65534), c_LU, 16'(i), 16'd0, 1'b1);
        end
        step("sat_hold", 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c_LU, 16'hFFFF, 16'd0, 1'b1);
        step("sat_hold2", 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c_LU, 16'hFFFF, 16'd0, 1'b1);
        step("clr_stall", 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c_LU, 16'hFFFF, 16'd0, 1'b1);
        idle("clr_done", c_IDLE, 16'd0, 16'd0, 1'b1);

        // Asynchronous reset mid-stall, then again mid-INIT
        step("pre_rst_busy", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, c_MEM, 16'd0, 16'd0, 1'b1);
        step("rst_mid_stall", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, c_INIT, 16'd0, 16'd0, 1'b0);
        idle("reinit_a0", c_INIT, 16'd0, 16'd0, 1'b0);
        idle("reinit_a1", c_INIT, 16'd0, 16'd0, 1'b0);
        step("rst_mid_init", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_INIT, 16'd0, 16'd0, 1'b0);
        idle("reinit_b0", c_INIT, 16'd0, 16'd0, 1'b0);
        idle("reinit_b1", c_INIT, 16'd0, 16'd0, 1'b0);
        idle("reinit_b2", c_INIT, 16'd0, 16'd0, 1'b0);
        idle("rerun", c_IDLE, 16'd0, 16'd0, 1'b0);

        chk = 1'b0;
        @(negedge clk);
        tests = tests + 1;
        if (q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
